// File: rtl/debouncer_multi_if.sv
// -----------------------------------------------------------------------------
// debouncer_multi_if
// Bundles the raw button inputs and the cleaned outputs of debouncer_multi.
//   master : drives btn, observes the debounced outputs (board side / bench)
//   slave  : the debouncer itself
// Signals (all N bits wide, one bit per channel):
//   btn           raw asynchronous button inputs
//   btn_db        debounced level
//   press_pulse   1-cycle pulse when btn_db rises
//   release_pulse 1-cycle pulse when btn_db falls
//   long_pulse    1-cycle pulse when the long-press threshold is reached
// -----------------------------------------------------------------------------
interface debouncer_multi_if #(
  parameter int N = 4
);
  logic [N-1:0] btn;
  logic [N-1:0] btn_db;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_pulse;

  modport master (
    output btn,
    input  btn_db, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  btn,
    output btn_db, press_pulse, release_pulse, long_pulse
  );
endinterface

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
// N independent push-button debouncers. Each channel has a 2-flop input
// synchroniser, a LOW/RISE/HIGH/FALL debounce FSM with its own counter, and
// registered level / press / release / long-press outputs.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  debouncer_multi_if.slave (btn in; btn_db, press_pulse,
//        release_pulse, long_pulse out)
// Parameters:
//   N           number of channels (>=1)
//   DB_CYCLES   stable synchronised cycles needed to accept a change (>=1)
//   RELEASE_DB  1 = debounce release as well, 0 = accept release at once
//   LONG_CYCLES cycles btn_db must stay high before long_pulse; 0 = off
// -----------------------------------------------------------------------------
module debouncer_multi #(
  parameter int N           = 4,
  parameter int DB_CYCLES   = 16,
  parameter int RELEASE_DB  = 1,
  parameter int LONG_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  debouncer_multi_if.slave  bus
);

  localparam int MAX_CYCLES = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);
  // Only meaningful when LONG_CYCLES > 0; every use is guarded by that test.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]    sync;
    logic          btn_s;
    state_t        state,  state_nxt;
    logic [CW-1:0] cnt,    cnt_nxt;
    logic          db,     db_nxt;
    logic          press,  press_nxt;
    logic          rel,    rel_nxt;
    logic          lng,    lng_nxt;

    // NOTE: the synchroniser flops are reset too, so a button held during
    // reset is seen as a fresh press afterwards instead of a stale level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync <= '0;
      end else begin
        sync <= {sync[0], bus.btn[i]};
      end
    end

    assign btn_s = sync[1];

    // NOTE: state registers use non-blocking assignments so every flop in
    // the design updates from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= S_LOW;
        cnt   <= '0;
        db    <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        db    <= db_nxt;
        press <= press_nxt;
        rel   <= rel_nxt;
        lng   <= lng_nxt;
      end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      db_nxt    = db;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      lng_nxt   = 1'b0;

      case (state)
        S_LOW: begin
          db_nxt  = 1'b0;
          cnt_nxt = '0;
          if (btn_s) state_nxt = S_RISE;
        end

        S_RISE: begin
          if (!btn_s) begin
            // Bounce: drop back silently, counter restarts on next entry.
            state_nxt = S_LOW;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = S_HIGH;
            db_nxt    = 1'b1;
            press_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        S_HIGH: begin
          // Release wins over a long-press firing in the same cycle.
          if (!btn_s) begin
            cnt_nxt = '0;
            if (RELEASE_DB != 0) begin
              state_nxt = S_FALL;
            end else begin
              state_nxt = S_LOW;
              db_nxt    = 1'b0;
              rel_nxt   = 1'b1;
            end
          end else if (LONG_CYCLES > 0) begin
            // Counter parks at LONG_CYCLES after firing: one pulse per press.
            if (cnt == LONG_LAST) begin
              lng_nxt = 1'b1;
              cnt_nxt = LONG_SAT;
            end else if (cnt < LONG_LAST) begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end

        S_FALL: begin
          if (btn_s) begin
            // Returning to HIGH saturated cancels any pending long-press.
            state_nxt = S_HIGH;
            cnt_nxt   = LONG_SAT;
          end else if (cnt == DB_LAST) begin
            state_nxt = S_LOW;
            db_nxt    = 1'b0;
            rel_nxt   = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        default: begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
        end
      endcase
    end

    assign bus.btn_db[i]        = db;
    assign bus.press_pulse[i]   = press;
    assign bus.release_pulse[i] = rel;
    assign bus.long_pulse[i]    = lng;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
// Two debouncer instances share clk/rst:
//   dut_a : N=4, DB_CYCLES=4, RELEASE_DB=1, LONG_CYCLES=10
//   dut_b : N=4, DB_CYCLES=1, RELEASE_DB=0, LONG_CYCLES=0
// Stimulus is driven 2 time units after a rising edge; cyc is then the number
// of edges so far. With btn changed at cyc=c, the FSM first sees the new level
// at edge c+3, so an accepted change appears at c+DB_CYCLES+3, a non-debounced
// release at c+3, and long_pulse LONG_CYCLES edges after btn_db rises.
// Expected output events are queued at stimulus time; a negedge monitor pops
// one whenever a DUT shows a pulse or a btn_db change and compares it.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

  typedef struct {
    int         cyc;
    logic [3:0] db;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int n_total  = 0;
  int n_passed = 0;

  ev_t qa[$];
  ev_t qb[$];

  debouncer_multi_if #(.N(4)) ifa ();
  debouncer_multi_if #(.N(4)) ifb ();

  debouncer_multi #(
    .N(4), .DB_CYCLES(4), .RELEASE_DB(1), .LONG_CYCLES(10)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  debouncer_multi #(
    .N(4), .DB_CYCLES(1), .RELEASE_DB(0), .LONG_CYCLES(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end else begin
      n_passed++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_a(input int at, input logic [3:0] db, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e = '{cyc: at, db: db, press: p, rel: r, lng: l};
    qa.push_back(e);
  endtask

  task automatic push_b(input int at, input logic [3:0] db, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e = '{cyc: at, db: db, press: p, rel: r, lng: l};
    qb.push_back(e);
  endtask

  // Monitor: one event per cycle in which a DUT shows any pulse or a level change.
  logic [3:0] prev_a = '0;
  logic [3:0] prev_b = '0;

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      prev_a = '0;
      prev_b = '0;
    end else begin
      if ((|ifa.press_pulse) || (|ifa.release_pulse) || (|ifa.long_pulse) ||
          (ifa.btn_db != prev_a)) begin
        check("a_event_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_event_cycle", cyc,              e.cyc);
          check("a_btn_db",      ifa.btn_db,        e.db);
          check("a_press",       ifa.press_pulse,   e.press);
          check("a_release",     ifa.release_pulse, e.rel);
          check("a_long",        ifa.long_pulse,    e.lng);
        end
      end
      if ((|ifb.press_pulse) || (|ifb.release_pulse) || (|ifb.long_pulse) ||
          (ifb.btn_db != prev_b)) begin
        check("b_event_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_event_cycle", cyc,              e.cyc);
          check("b_btn_db",      ifb.btn_db,        e.db);
          check("b_press",       ifb.press_pulse,   e.press);
          check("b_release",     ifb.release_pulse, e.rel);
          check("b_long",        ifb.long_pulse,    e.lng);
        end
      end
      prev_a = ifa.btn_db;
      prev_b = ifb.btn_db;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    ifa.btn = '0;
    ifb.btn = '0;

    // Reset asserted between edges clears outputs immediately.
    #1 rst = 1'b1;
    #2;
    check("rst_a_db",    ifa.btn_db,                                           32'd0);
    check("rst_a_pulse", {ifa.press_pulse, ifa.release_pulse, ifa.long_pulse}, 32'd0);
    check("rst_b_db",    ifb.btn_db,                                           32'd0);
    check("rst_b_pulse", {ifb.press_pulse, ifb.release_pulse, ifb.long_pulse}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(20);
    check("idle_a_db", ifa.btn_db, 32'd0);
    check("idle_b_db", ifb.btn_db, 32'd0);

    // Clean press on channel 0, then reset while held aborts it.
    c = cyc;
    ifa.btn[0] = 1'b1;
    push_a(c + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    idle(9);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_a_db",   ifa.btn_db,      32'd0);
    check("rst_mid_a_long", ifa.long_pulse,  32'd0);
    ifa.btn = '0;
    idle(3);
    rst = 1'b0;
    idle(20);

    // Clean press, long pulse while held, debounced release on channel 0.
    c = cyc;
    ifa.btn[0] = 1'b1;
    push_a(c + 7,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push_a(c + 17, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    idle(20);
    ifa.btn[0] = 1'b0;
    push_a(c + 27, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    idle(15);

    // Channel 1: 3-cycle glitch rejected, then a 10-cycle press accepted.
    ifa.btn[1] = 1'b1;
    idle(3);
    ifa.btn[1] = 1'b0;
    idle(10);
    c = cyc;
    ifa.btn[1] = 1'b1;
    push_a(c + 7, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    idle(10);
    ifa.btn[1] = 1'b0;
    push_a(c + 17, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    idle(15);

    // Channel 2: 30-cycle hold gives exactly one long pulse.
    c = cyc;
    ifa.btn[2] = 1'b1;
    push_a(c + 7,  4'b0100, 4'b0100, 4'b0000, 4'b0000);
    push_a(c + 17, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    idle(30);
    ifa.btn[2] = 1'b0;
    push_a(c + 37, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    idle(12);

    // Channel 2: short hold released before the long threshold.
    c = cyc;
    ifa.btn[2] = 1'b1;
    push_a(c + 7, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    idle(12);
    ifa.btn[2] = 1'b0;
    push_a(c + 19, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    idle(12);

    // Channel 3: 2-cycle bounce during release suppresses long pulse; release
    // accepted 7 cycles after the final low.
    c = cyc;
    ifa.btn[3] = 1'b1;
    push_a(c + 7, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    idle(9);
    ifa.btn[3] = 1'b0;
    idle(2);
    ifa.btn[3] = 1'b1;
    idle(2);
    ifa.btn[3] = 1'b0;
    push_a(c + 20, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    idle(15);

    // All four channels pressed together, staggered releases.
    c = cyc;
    ifa.btn = 4'hF;
    push_a(c + 7,  4'hF, 4'hF, 4'h0, 4'h0);
    push_a(c + 17, 4'hF, 4'h0, 4'h0, 4'hF);
    idle(20);
    ifa.btn[0] = 1'b0;
    push_a(c + 27, 4'b1110, 4'b0000, 4'b0001, 4'b0000);
    idle(2);
    ifa.btn[1] = 1'b0;
    push_a(c + 29, 4'b1100, 4'b0000, 4'b0010, 4'b0000);
    idle(3);
    ifa.btn[2] = 1'b0;
    push_a(c + 32, 4'b1000, 4'b0000, 4'b0100, 4'b0000);
    idle(2);
    ifa.btn[3] = 1'b0;
    push_a(c + 34, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    idle(12);

    // dut_b, DB_CYCLES=1: a 1-cycle pulse never reaches a stable RISE cycle.
    ifb.btn[0] = 1'b1;
    idle(1);
    ifb.btn[0] = 1'b0;
    idle(8);

    // dut_b: 2-cycle pulse gives btn_db high for exactly one cycle;
    // undebounced release lands 3 edges after btn falls.
    c = cyc;
    ifb.btn[0] = 1'b1;
    push_b(c + 4, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    idle(2);
    ifb.btn[0] = 1'b0;
    push_b(c + 5, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    idle(8);

    // dut_b: channels 1 and 3 together, independent releases, no long pulse.
    c = cyc;
    ifb.btn = 4'b1010;
    push_b(c + 4, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
    idle(5);
    ifb.btn[3] = 1'b0;
    push_b(c + 8, 4'b0010, 4'b0000, 4'b1000, 4'b0000);
    idle(4);
    ifb.btn[1] = 1'b0;
    push_b(c + 12, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    idle(10);

    check("a_events_left", qa.size(), 32'd0);
    check("b_events_left", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- N-channel successor to the single-button debouncer: per-channel 2-flop input synchroniser, per-channel debounce FSM and counter, registered level and event outputs.
- Adds parametrised debounce time, optional release debouncing, press/release edge pulses and a long-press pulse.
- Sits between raw board push-buttons/switches and control logic that consumes clean levels or single-cycle events.

Parameters:
- N, 4, number of independent channels (>=1).
- DB_CYCLES, 16, consecutive stable synchronised cycles required to accept a level change (>=1).
- RELEASE_DB, 1, 1 = falling edge is debounced like the rising edge; 0 = release is accepted immediately.
- LONG_CYCLES, 0, cycles btn_db must stay high before long_pulse fires; 0 = long-press disabled.
- Counter width CW = clog2(max(DB_CYCLES, LONG_CYCLES) + 1), derived locally, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- btn  in  N  raw asynchronous button inputs.
- btn_db  out  N  debounced level.
- press_pulse  out  N  1-cycle pulse when btn_db rises.
- release_pulse  out  N  1-cycle pulse when btn_db falls.
- long_pulse  out  N  1-cycle pulse when the long-press threshold is reached.

Behaviour:
- Reset (rst=1, asynchronous): synchroniser flops 0, state LOW, cnt 0, all outputs 0. After rst deasserts, operation resumes from the next clk edge. Reset asserted mid-debounce aborts the debounce with no pulses.
- Synchroniser: btn_s[i] is btn[i] after 2 flops. All FSM decisions use btn_s only.
- Channels are fully independent; no shared state between channels.
- All outputs are registered. Each pulse is high for exactly one cycle.

Per-channel FSM states, evaluated at each clk edge:
- LOW:
  - btn_db=0.
  - btn_s=1 -> RISE, cnt<=0.
- RISE:
  - btn_s=0 -> LOW, cnt<=0. This is a rejected bounce: no pulse.
  - btn_s=1 and cnt==DB_CYCLES-1 -> HIGH, btn_db<=1, press_pulse<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- HIGH:
  - btn_s=0 with RELEASE_DB=1 -> FALL, cnt<=0.
  - btn_s=0 with RELEASE_DB=0 -> LOW, btn_db<=0, release_pulse<=1.
  - btn_s=1, LONG_CYCLES>0 and cnt==LONG_CYCLES-1 -> long_pulse<=1, cnt<=LONG_CYCLES (saturates, so it fires once per press).
  - btn_s=1 and cnt<LONG_CYCLES-1 -> cnt<=cnt+1.
  - Release has priority over long_pulse in the same cycle.
- FALL:
  - btn_db stays 1.
  - btn_s=1 -> HIGH, cnt<=LONG_CYCLES. A bounce during release suppresses any not-yet-fired long_pulse for this press.
  - btn_s=0 and cnt==DB_CYCLES-1 -> LOW, btn_db<=0, release_pulse<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- Unused state encodings -> LOW, cnt 0, outputs 0 (fault recovery).

Latency:
- Count edge 0 as the first clk edge that samples a new, stable btn level.
- btn_db and press_pulse assert after edge DB_CYCLES+2.
- Release takes the same latency when RELEASE_DB=1, and 3 edges when RELEASE_DB=0.
- long_pulse asserts LONG_CYCLES edges after btn_db rises.

Boundaries:
- DB_CYCLES=1: one stable cycle in RISE is enough.
- A glitch of fewer than DB_CYCLES cycles never changes btn_db.
- A toggle in RISE or FALL restarts the counter from 0 on the next entry.
- cnt never wraps: in HIGH it saturates at LONG_CYCLES; elsewhere it is bounded by DB_CYCLES-1.

Test Plan:
- Reset: N=4, DB_CYCLES=4. Assert rst asynchronously between clk edges -> all outputs 0 immediately. Deassert, hold btn=0 for 20 cycles -> outputs stay 0.
- Clean press: btn[0] goes 0->1 and is held -> btn_db[0]=1 and press_pulse[0]=1 (one cycle) after edge 6. Channels 1-3 unaffected.
- Bounce rejection: DB_CYCLES=4, btn[1] high for 3 cycles then low -> btn_db[1]=0 and no pulses. Then high for 10 cycles -> press accepted exactly 6 edges after the final rise.
- Release modes: RELEASE_DB=1, release with a 2-cycle bounce -> btn_db stays 1 and the release is accepted 6 edges after the final stable low, release_pulse 1 cycle. RELEASE_DB=0 -> btn_db falls 3 edges after btn falls.
- Long press: LONG_CYCLES=10, hold btn[2] for 30 cycles -> exactly one long_pulse, 10 edges after btn_db rises. Hold for only 8 -> no long_pulse. A bounce during FALL before the threshold -> no long_pulse.
- Simultaneous channels: all 4 buttons pressed on the same edge -> all press_pulse bits assert on the same edge. Staggered releases -> independent release_pulse bits with correct per-channel latency.
